// File: rtl/flash_bus_pkg.sv
// Shared types and constants for the ROM-Flash bus controller.
package flash_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } port_t;

    localparam logic [11:0] REGION_TAG_DEFAULT = 12'h080;
    localparam logic [31:0] WORD_ALIGN_MASK    = 32'h0000_0003;

    // True when an address is not word aligned or falls outside the flash window.
    function automatic logic addr_fault(input logic [31:0] addr, input logic [11:0] tag);
        return ((addr & WORD_ALIGN_MASK) != 32'd0) || (addr[31:20] != tag);
    endfunction

endpackage

// File: rtl/flash_bus_ctrl_if.sv
// Bus bundle between the core's fetch/load-store ports, the controller and the flash pins.
interface flash_bus_ctrl_if;
    import flash_bus_pkg::*;

    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    logic [31:0] fetch_rdata;
    logic        fetch_err;

    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_ack;
    logic [31:0] data_rdata;
    logic        data_err;

    logic        flash_unlock;

    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_write_enable;
    logic [31:0] mem_data_out;

    logic        busy;

    // Requesters plus the flash block: they drive requests and flash read data.
    modport master (
        output fetch_req, fetch_addr,
        input  fetch_ack, fetch_rdata, fetch_err,
        output data_req, data_we, data_addr, data_wdata,
        input  data_ack, data_rdata, data_err,
        output flash_unlock,
        input  mem_address, mem_data_in, mem_write_enable,
        output mem_data_out,
        input  busy
    );

    // The controller side.
    modport slave (
        input  fetch_req, fetch_addr,
        output fetch_ack, fetch_rdata, fetch_err,
        input  data_req, data_we, data_addr, data_wdata,
        output data_ack, data_rdata, data_err,
        input  flash_unlock,
        output mem_address, mem_data_in, mem_write_enable,
        input  mem_data_out,
        output busy
    );

endinterface

// File: rtl/flash_bus_ctrl_arbiter.sv
// Two-way round-robin arbiter: on a tie the port that did not win last time is granted.
module rr_arbiter2
    import flash_bus_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  enable,
    input  logic  req_fetch,
    input  logic  req_data,
    output logic  grant_valid,
    output port_t grant_port
);

    port_t last_grant;

    // Pick a winner; a tie goes to whichever port was not granted last.
    always_comb begin
        grant_valid = enable && (req_fetch || req_data);
        grant_port  = FETCH;
        if (req_fetch && req_data) begin
            grant_port = (last_grant == FETCH) ? DATA : FETCH;
        end else if (req_data) begin
            grant_port = DATA;
        end
    end

    // Remember the winner only when a grant is actually taken; reset favours fetch first.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= DATA;
        end else if (grant_valid) begin
            last_grant <= grant_port;
        end
    end

endmodule

// File: rtl/flash_bus_ctrl.sv
// Sequencer for the 1 MB ROM-Flash window: arbitrates fetch and data ports,
// checks alignment/region/write-protect, runs one flash word access at a time.
module flash_bus_ctrl
    import flash_bus_pkg::*;
#(
    parameter logic [11:0] REGION_TAG   = REGION_TAG_DEFAULT,
    parameter int unsigned READ_LATENCY = 1
) (
    input logic        clock,
    input logic        reset,
    flash_bus_ctrl_if.slave bus
);

    localparam logic [3:0] LAT_LAST = 4'(READ_LATENCY - 1);

    state_t      state_q, state_d;
    port_t       port_q, port_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  lat_q, lat_d;

    logic        grant_valid;
    port_t       grant_port;
    logic [31:0] sel_addr;
    logic        sel_we;
    logic [31:0] sel_wdata;
    logic        fault;
    logic        resp_fetch;
    logic        resp_data;

    rr_arbiter2 u_arbiter (
        .clock       (clock),
        .reset       (reset),
        .enable      (state_q == IDLE),
        .req_fetch   (bus.fetch_req),
        .req_data    (bus.data_req),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    // State and latched-request registers; reset aborts any access in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            port_q  <= FETCH;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            lat_q   <= lat_d;
        end
    end

    // Next-state, request decode, latency countdown and pin/response outputs.
    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        lat_d   = lat_q;

        sel_addr  = (grant_port == DATA) ? bus.data_addr : bus.fetch_addr;
        sel_we    = (grant_port == DATA) && bus.data_we;
        sel_wdata = (grant_port == DATA) ? bus.data_wdata : 32'd0;
        fault     = addr_fault(sel_addr, REGION_TAG) || (sel_we && !bus.flash_unlock);

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    port_d  = grant_port;
                    addr_d  = sel_addr;
                    we_d    = sel_we;
                    wdata_d = sel_wdata;
                    err_d   = fault;
                    rdata_d = '0;
                    lat_d   = LAT_LAST;
                    state_d = fault ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                state_d = we_q ? RESP : WAIT;
            end
            WAIT: begin
                if (lat_q == 4'd0) begin
                    rdata_d = bus.mem_data_out;
                    state_d = RESP;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        resp_fetch = (state_q == RESP) && (port_q == FETCH);
        resp_data  = (state_q == RESP) && (port_q == DATA);

        bus.fetch_ack   = resp_fetch;
        bus.fetch_err   = resp_fetch && err_q;
        bus.fetch_rdata = resp_fetch ? rdata_q : 32'd0;
        bus.data_ack    = resp_data;
        bus.data_err    = resp_data && err_q;
        bus.data_rdata  = resp_data ? rdata_q : 32'd0;

        bus.mem_address      = ((state_q == ISSUE) || (state_q == WAIT)) ? addr_q : 32'd0;
        bus.mem_write_enable = (state_q == ISSUE) && we_q;
        bus.mem_data_in      = ((state_q == ISSUE) && we_q) ? wdata_q : 32'd0;
        bus.busy             = (state_q != IDLE);
    end

endmodule
